io_output_pipe: RTL and testbench
=================================

# io_output_pipe

Parametrised, multi-bit output register stage with a registered tristate enable. It sits between core logic and the top-level pads. It accepts data words with a valid/stall handshake, delays them through a configurable pipeline, and drives the final pad register. Between updates it holds the last value. The final stage is a bare register level with no logic after it, so it packs into the PIO output flop.

## Interface
Parameters:
- WIDTH, 1, number of output channels (1..64).
- DEPTH, 2, total register stages including the final pad stage (1..8).
- RESET_VALUE, 0, WIDTH-bit value driven on Q while and after RESET.
- OE_RESET, 0, 1-bit value replicated onto every OE_Q bit at reset.

Ports:
- CLK, in, 1, clock; all state updates on rising edge.
- RESET, in, 1, reset, synchronous, active-high.
- STALL, in, 1, freezes every stage, including the pad stage.
- IN_VALID, in, 1, IN_DATA/IN_OE carry a word this cycle.
- IN_READY, out, 1, word accepted when IN_VALID && IN_READY; equals !STALL, combinational.
- IN_DATA, in, WIDTH, data word.
- IN_OE, in, WIDTH, per-channel output enable, travels with IN_DATA.
- Q, out, WIDTH, pad data, direct register output.
- OE_Q, out, WIDTH, pad output enable, active-high, direct register output.
- IDLE, out, 1, high when no valid word is in stages 1..DEPTH-1 (always 1 when DEPTH=1).

## Operation
- Internal stages s1..s(DEPTH-1) each hold data, oe and a valid bit. The pad stage sDEPTH holds Q/OE_Q and has no valid bit.
- When STALL=0, on each edge:
  - s1 loads {IN_DATA, IN_OE, IN_VALID}.
  - s(k) loads s(k-1).
  - The pad stage loads the data and oe of s(DEPTH-1) only if s(DEPTH-1).valid=1; otherwise Q/OE_Q hold.
- DEPTH=1: the pad stage loads IN_DATA/IN_OE directly when IN_VALID=1 and STALL=0.
- When STALL=1, all registers, including valid bits and Q/OE_Q, hold. IN_VALID is ignored because IN_READY=0.
- Bubbles (valid=0) propagate like data. They never modify Q/OE_Q.
- RESET:
  - All valid bits clear.
  - Q=RESET_VALUE and OE_Q={WIDTH{OE_RESET}}.
  - Internal data/oe registers clear to 0.
- RESET has priority over STALL and IN_VALID.
- Reset mid-operation discards every in-flight word. The first word accepted after RESET deasserts appears DEPTH cycles later.
- IDLE is the NOR of s1..s(DEPTH-1) valid bits, registered-derived and glitch-free.

## Timing
- Latency: a word accepted at edge t is on Q/OE_Q after edge t+DEPTH-1. That is DEPTH edges counting the acceptance edge, with no stall.
- Each stall cycle adds exactly one cycle of latency to every in-flight word. Word order and count are preserved.
- Throughput: one word per cycle while STALL=0.
- Reset values, visible the cycle after the RESET edge:
  - Q=RESET_VALUE
  - OE_Q={WIDTH{OE_RESET}}
  - IDLE=1
  - IN_READY=!STALL (combinational, unaffected by reset)
- A word accepted in the same cycle RESET is high is dropped.

## Configuration
- Macro: IO_OUTPUT_PIPE_UPDCNT_EN.
- Defined: adds output UPD_COUNT, 16 bits.
  - Increments by 1 on every edge where Q/OE_Q load a new word.
  - The increment happens even if the new word equals the current value.
  - Saturates at 16'hFFFF.
  - Clears to 0 on RESET.
- Undefined: port and counter absent. Pipeline behaviour is identical.

## Test plan
- Reset values: WIDTH=8, RESET_VALUE=8'hA5, OE_RESET=1, hold RESET 2 cycles -> Q=8'hA5, OE_Q=8'hFF, IDLE=1.
- Latency, DEPTH=3:
  - Stimulus: accept 8'h01,8'h02,8'h03 back-to-back.
  - Required: Q shows 01,02,03 on the 3rd,4th,5th edges after the first acceptance, then holds 03.
  - Required: IDLE returns to 1 after the last word leaves s2.
- Stall, DEPTH=3:
  - Stimulus: stream 10,11,12 with STALL=1 for 2 cycles mid-stream.
  - Required: IN_READY=0 during the stall, no word lost or duplicated, Q sequence 10,11,12, each word delayed by 2 cycles.
- Bubbles: words 20,_,_,21 with IN_VALID low in the gaps -> Q holds 20 for 3 cycles, then 21; OE_Q follows IN_OE of each word.
- Reset mid-flight: two words in s1/s2, RESET one cycle -> Q=RESET_VALUE, IDLE=1, neither word ever appears on Q.
- DEPTH=1 with IO_OUTPUT_PIPE_UPDCNT_EN defined:
  - Stimulus: 5 valid words.
  - Required: Q updates the edge after each acceptance and UPD_COUNT=5.
  - Stimulus: force 70000 valid words.
  - Required: UPD_COUNT=16'hFFFF.

Source files
------------

// File: rtl/io_output_pipe.sv
// io_output_pipe
//   Registered output stage for pad drivers. Words (data + per-channel output
//   enable) enter through a valid/stall handshake, travel through DEPTH-1
//   internal stages, and are finally captured by a bare pad register that
//   holds its value between updates. Bubbles never disturb the pad register.
//
// Parameters
//   WIDTH       : number of output channels (1..64)
//   DEPTH       : register stages including the pad stage (1..8)
//   RESET_VALUE : value on Q during and after RESET
//   OE_RESET    : value replicated onto every OE_Q bit at reset
//
// Ports
//   CLK       in   clock, rising edge
//   RESET     in   synchronous, active-high; beats STALL and IN_VALID
//   STALL     in   freezes every stage including the pad stage
//   IN_VALID  in   IN_DATA/IN_OE carry a word
//   IN_READY  out  !STALL (combinational)
//   IN_DATA   in   data word
//   IN_OE     in   per-channel output enable
//   Q         out  pad data (register output)
//   OE_Q      out  pad output enable (register output)
//   IDLE      out  no valid word in internal stages
//   UPD_COUNT out  saturating count of pad updates (only with
//                  IO_OUTPUT_PIPE_UPDCNT_EN defined)
module io_output_pipe #(
  parameter int unsigned        WIDTH       = 1,
  parameter int unsigned        DEPTH       = 2,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter logic               OE_RESET    = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic [WIDTH-1:0] IN_OE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] OE_Q,
  output logic             IDLE
`ifdef IO_OUTPUT_PIPE_UPDCNT_EN
  ,
  output logic [15:0]      UPD_COUNT
`endif
);

  logic             pad_load;
  logic [WIDTH-1:0] pad_data;
  logic [WIDTH-1:0] pad_oe;

  assign IN_READY = ~STALL;

  if (DEPTH == 1) begin : g_direct
    assign pad_load = IN_VALID & ~STALL;
    assign pad_data = IN_DATA;
    assign pad_oe   = IN_OE;
    assign IDLE     = 1'b1;
  end else begin : g_pipe
    localparam int unsigned NS = DEPTH - 1;

    logic [WIDTH-1:0] dat_q [NS];
    logic [WIDTH-1:0] oen_q [NS];
    logic             vld_q [NS];
    logic             any_vld;

    always_ff @(posedge CLK) begin
      if (RESET) begin
        for (int unsigned i = 0; i < NS; i++) begin
          dat_q[i] <= '0;
          oen_q[i] <= '0;
          vld_q[i] <= 1'b0;
        end
      end else if (!STALL) begin
        dat_q[0] <= IN_DATA;
        oen_q[0] <= IN_OE;
        vld_q[0] <= IN_VALID;
        for (int unsigned i = 1; i < NS; i++) begin
          dat_q[i] <= dat_q[i-1];
          oen_q[i] <= oen_q[i-1];
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    always_comb begin
      any_vld = 1'b0;
      for (int unsigned i = 0; i < NS; i++) begin
        any_vld = any_vld | vld_q[i];
      end
    end

    assign IDLE     = ~any_vld;
    assign pad_load = vld_q[NS-1] & ~STALL;
    assign pad_data = dat_q[NS-1];
    assign pad_oe   = oen_q[NS-1];
  end

  // Pad stage: next value chosen ahead so the register itself has no logic
  // between its output and the pin.
  logic [WIDTH-1:0] q_d, q_q;
  logic [WIDTH-1:0] oe_d, oe_q;

  always_comb begin
    q_d  = q_q;
    oe_d = oe_q;
    if (pad_load) begin
      q_d  = pad_data;
      oe_d = pad_oe;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_q  <= RESET_VALUE;
      oe_q <= {WIDTH{OE_RESET}};
    end else begin
      q_q  <= q_d;
      oe_q <= oe_d;
    end
  end

  assign Q    = q_q;
  assign OE_Q = oe_q;

`ifdef IO_OUTPUT_PIPE_UPDCNT_EN
  logic [15:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (pad_load && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign UPD_COUNT = cnt_q;
`endif

endmodule

// File: tb/tb_io_output_pipe.sv
// Scoreboard bench for io_output_pipe: a DEPTH=3 instance and a DEPTH=1
// instance share the clock. Stimulus tasks push expected pad words with the
// cycle they are due; per-instance monitors pop and compare at that cycle
// and check that the pad holds in between.
module tb_io_output_pipe;

  localparam int NOKILL = 32'h7fffffff;

  typedef struct {
    logic [7:0]  d;
    logic [7:0]  oe;
    int          due;
    int          acc;
    bit          mk;
    int          kill;
    logic [15:0] cnt;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // DEPTH=3 instance signals
  logic       rs3 = 1'b1, st3 = 1'b0, v3 = 1'b0, rdy3, idle3;
  logic [7:0] d3 = '0, oe3i = '0, q3o, oe3o;
  // DEPTH=1 instance signals
  logic       rs1 = 1'b1, st1 = 1'b0, v1 = 1'b0, rdy1, idle1;
  logic [7:0] d1 = '0, oe1i = '0, q1o, oe1o;
`ifdef IO_OUTPUT_PIPE_UPDCNT_EN
  logic [15:0] cnt3o, cnt1o;
`endif

  io_output_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5), .OE_RESET(1'b1)) u3 (
    .CLK(clk), .RESET(rs3), .STALL(st3), .IN_VALID(v3), .IN_READY(rdy3),
    .IN_DATA(d3), .IN_OE(oe3i), .Q(q3o), .OE_Q(oe3o), .IDLE(idle3)
`ifdef IO_OUTPUT_PIPE_UPDCNT_EN
    , .UPD_COUNT(cnt3o)
`endif
  );

  io_output_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h3C), .OE_RESET(1'b0)) u1 (
    .CLK(clk), .RESET(rs1), .STALL(st1), .IN_VALID(v1), .IN_READY(rdy1),
    .IN_DATA(d1), .IN_OE(oe1i), .Q(q1o), .OE_Q(oe1o), .IDLE(idle1)
`ifdef IO_OUTPUT_PIPE_UPDCNT_EN
    , .UPD_COUNT(cnt1o)
`endif
  );

  ent_t sb3[$];
  ent_t sb1[$];
  logic [15:0] cnt1m = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  function automatic ent_t mk_ent(input logic [7:0] d, input logic [7:0] oe, input int due,
                                  input int acc, input bit mk, input logic [15:0] cnt);
    ent_t e;
    e.d = d; e.oe = oe; e.due = due; e.acc = acc; e.mk = mk; e.kill = NOKILL; e.cnt = cnt;
    return e;
  endfunction

  // Drive one cycle of the DEPTH=3 instance and record what the pad must show.
  task automatic s3(input bit v, input logic [7:0] d, input logic [7:0] oe, input bit st, input bit rs);
    @(posedge clk); #2;
    v3 = v; d3 = d; oe3i = oe; st3 = st; rs3 = rs;
    if (rs) begin
      foreach (sb3[i]) if (sb3[i].due > cyc) sb3[i].kill = cyc + 1;
      sb3.push_back(mk_ent(8'hA5, 8'hFF, cyc + 1, cyc + 1, 1'b1, 16'h0));
    end else if (st) begin
      foreach (sb3[i]) if (sb3[i].due > cyc) sb3[i].due++;
    end else if (v) begin
      sb3.push_back(mk_ent(d, oe, cyc + 3, cyc + 1, 1'b0, 16'h0));
    end
  endtask

  task automatic s1(input bit v, input logic [7:0] d, input logic [7:0] oe, input bit st, input bit rs);
    @(posedge clk); #2;
    v1 = v; d1 = d; oe1i = oe; st1 = st; rs1 = rs;
    if (rs) begin
      foreach (sb1[i]) if (sb1[i].due > cyc) sb1[i].kill = cyc + 1;
      cnt1m = '0;
      sb1.push_back(mk_ent(8'h3C, 8'h00, cyc + 1, cyc + 1, 1'b1, 16'h0));
    end else if (st) begin
      foreach (sb1[i]) if (sb1[i].due > cyc) sb1[i].due++;
    end else if (v) begin
      if (cnt1m != 16'hFFFF) cnt1m = cnt1m + 16'd1;
      sb1.push_back(mk_ent(d, oe, cyc + 1, cyc + 1, 1'b0, cnt1m));
    end
  endtask

  ent_t e3, e1;
  bit   have3 = 1'b0, have1 = 1'b0;

  always @(negedge clk) begin
    bit idle_exp;
    for (int i = sb3.size() - 1; i >= 0; i--) if (sb3[i].kill <= cyc) sb3.delete(i);
    if (sb3.size() > 0 && sb3[0].due < cyc) begin
      chk("late3", cyc, sb3[0].due);
      void'(sb3.pop_front());
    end
    if (sb3.size() > 0 && sb3[0].due == cyc) begin
      e3 = sb3.pop_front();
      have3 = 1'b1;
    end
    if (have3) begin
      chk("q3", {24'h0, q3o}, {24'h0, e3.d});
      chk("oe3", {24'h0, oe3o}, {24'h0, e3.oe});
      idle_exp = 1'b1;
      foreach (sb3[i]) if (!sb3[i].mk && sb3[i].acc <= cyc && sb3[i].due > cyc) idle_exp = 1'b0;
      chk("idle3", {31'h0, idle3}, {31'h0, idle_exp});
    end
    chk("rdy3", {31'h0, rdy3}, {31'h0, ~st3});
  end

  always @(negedge clk) begin
    for (int i = sb1.size() - 1; i >= 0; i--) if (sb1[i].kill <= cyc) sb1.delete(i);
    if (sb1.size() > 0 && sb1[0].due < cyc) begin
      chk("late1", cyc, sb1[0].due);
      void'(sb1.pop_front());
    end
    if (sb1.size() > 0 && sb1[0].due == cyc) begin
      e1 = sb1.pop_front();
      have1 = 1'b1;
    end
    if (have1) begin
      chk("q1", {24'h0, q1o}, {24'h0, e1.d});
      chk("oe1", {24'h0, oe1o}, {24'h0, e1.oe});
      chk("idle1", {31'h0, idle1}, 32'h1);
`ifdef IO_OUTPUT_PIPE_UPDCNT_EN
      chk("cnt1", {16'h0, cnt1o}, {16'h0, e1.cnt});
`endif
    end
    chk("rdy1", {31'h0, rdy1}, {31'h0, ~st1});
  end

  initial begin
    // Reset values on the DEPTH=3 instance
    s3(0, 8'h00, 8'h00, 0, 1);
    s3(0, 8'h00, 8'h00, 0, 1);
    // Latency: three back-to-back words, then drain
    s3(1, 8'h01, 8'h0F, 0, 0);
    s3(1, 8'h02, 8'hF0, 0, 0);
    s3(1, 8'h03, 8'h3C, 0, 0);
    repeat (4) s3(0, 8'h00, 8'h00, 0, 0);
    // Stall mid-stream; the word offered during the stall must be ignored
    s3(1, 8'h10, 8'h11, 0, 0);
    s3(1, 8'h11, 8'h22, 0, 0);
    s3(1, 8'hEE, 8'hEE, 1, 0);
    s3(1, 8'hEE, 8'hEE, 1, 0);
    s3(1, 8'h12, 8'h33, 0, 0);
    repeat (5) s3(0, 8'h00, 8'h00, 0, 0);
    // Bubbles between words
    s3(1, 8'h20, 8'h55, 0, 0);
    s3(0, 8'h99, 8'h99, 0, 0);
    s3(0, 8'h99, 8'h99, 0, 0);
    s3(1, 8'h21, 8'hAA, 0, 0);
    repeat (4) s3(0, 8'h00, 8'h00, 0, 0);
    // Reset with two words in flight; the word offered with RESET is dropped
    s3(1, 8'h30, 8'h01, 0, 0);
    s3(1, 8'h31, 8'h02, 0, 0);
    s3(1, 8'h32, 8'h04, 0, 1);
    repeat (3) s3(0, 8'h00, 8'h00, 0, 0);
    s3(1, 8'h40, 8'h08, 0, 0);
    repeat (4) s3(0, 8'h00, 8'h00, 0, 0);

    // DEPTH=1 instance
    s1(0, 8'h00, 8'h00, 0, 1);
    s1(0, 8'h00, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) s1(1, 8'h50 + 8'(i), 8'hF0 ^ 8'(i), 0, 0);
    s1(1, 8'hEE, 8'hEE, 1, 0);
    s1(0, 8'h77, 8'h77, 0, 0);
    s1(1, 8'h55, 8'h0F, 0, 0);
    s1(1, 8'h55, 8'h0F, 0, 0);
    s1(0, 8'h00, 8'h00, 0, 0);
`ifdef IO_OUTPUT_PIPE_UPDCNT_EN
    for (int i = 0; i < 70000; i++) s1(1, 8'(i), 8'(i >> 3), 0, 0);
    s1(0, 8'h00, 8'h00, 0, 0);
    s1(0, 8'h00, 8'h00, 0, 0);
    @(negedge clk); #1;
    chk("cnt_sat", {16'h0, cnt1o}, 32'h0000FFFF);
`endif
    repeat (3) s1(0, 8'h00, 8'h00, 0, 0);
    @(negedge clk); #1;
    chk("drain3", sb3.size(), 0);
    chk("drain1", sb1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
